// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: loads one 512-bit block as 16 words, then streams
// W_t / K_t for t = 0..63 under a valid/ready handshake.
module sha256_msg_sched (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        CLR,
  input  logic        MSG_VALID,
  output logic        MSG_READY,
  input  logic [31:0] MSG_DATA,
  output logic        W_VALID,
  input  logic        W_READY,
  output logic [31:0] W_DATA,
  output logic [31:0] K_DATA,
  output logic [5:0]  W_IDX,
  output logic        W_LAST,
  output logic        BUSY
);

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_load_cnt;
  logic [3:0]  w_load_cnt_next;
  logic [5:0]  r_idx;
  logic [5:0]  w_idx_next;
  logic [31:0] r_win      [16];
  logic [31:0] w_win_next [16];

  logic        w_load_acc;
  logic        w_run_acc;
  logic        w_shift;
  logic [31:0] w_shift_in;
  logic [31:0] w_sig0;
  logic [31:0] w_sig1;
  logic [31:0] w_sched_new;

  // Slot 14 is W_{t-2}, slot 9 is W_{t-7}, slot 1 is W_{t-15}, slot 0 is W_{t-16}.
  assign w_sig0 = {r_win[1][6:0],   r_win[1][31:7]}
                ^ {r_win[1][17:0],  r_win[1][31:18]}
                ^ {3'b000,          r_win[1][31:3]};
  assign w_sig1 = {r_win[14][16:0], r_win[14][31:17]}
                ^ {r_win[14][18:0], r_win[14][31:19]}
                ^ {10'd0,           r_win[14][31:10]};
  assign w_sched_new = w_sig1 + r_win[9] + w_sig0 + r_win[0];

  assign w_load_acc = (r_state == ST_LOAD) & MSG_VALID;
  assign w_run_acc  = (r_state == ST_RUN) & W_READY;
  assign w_shift    = ~CLR & (w_load_acc | w_run_acc);
  assign w_shift_in = (r_state == ST_LOAD) ? MSG_DATA : w_sched_new;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_win
      if (gi == 15) begin : g_top
        assign w_win_next[gi] = w_shift_in;
      end else begin : g_mid
        assign w_win_next[gi] = r_win[gi+1];
      end
    end
  endgenerate

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < 16; i++) begin
        r_win[i] <= '0;
      end
    end else if (w_shift) begin
      r_win <= w_win_next;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state    <= ST_LOAD;
      r_load_cnt <= '0;
      r_idx      <= '0;
    end else begin
      r_state    <= w_state_next;
      r_load_cnt <= w_load_cnt_next;
      r_idx      <= w_idx_next;
    end
  end

  // CLR wins over any handshake in the same cycle.
  always_comb begin
    w_state_next    = r_state;
    w_load_cnt_next = r_load_cnt;
    w_idx_next      = r_idx;
    MSG_READY       = 1'b0;
    W_VALID         = 1'b0;
    BUSY            = 1'b0;
    case (r_state)
      ST_LOAD: begin
        MSG_READY = 1'b1;
        if (MSG_VALID) begin
          w_load_cnt_next = r_load_cnt + 4'd1;
          if (r_load_cnt == 4'd15) begin
            w_state_next = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        W_VALID = 1'b1;
        BUSY    = 1'b1;
        if (W_READY) begin
          w_idx_next = r_idx + 6'd1;
          if (r_idx == 6'd63) begin
            w_state_next    = ST_LOAD;
            w_load_cnt_next = '0;
          end
        end
      end
      default: begin
        w_state_next = ST_LOAD;
      end
    endcase
    if (CLR) begin
      w_state_next    = ST_LOAD;
      w_load_cnt_next = '0;
      w_idx_next      = '0;
    end
  end

  assign W_DATA = r_win[0];
  assign W_IDX  = r_idx;
  assign W_LAST = W_VALID & (r_idx == 6'd63);

  always_comb begin
    K_DATA = '0;
    case (r_idx)
      6'd0:  K_DATA = 32'h428a2f98;
      6'd1:  K_DATA = 32'h71374491;
      6'd2:  K_DATA = 32'hb5c0fbcf;
      6'd3:  K_DATA = 32'he9b5dba5;
      6'd4:  K_DATA = 32'h3956c25b;
      6'd5:  K_DATA = 32'h59f111f1;
      6'd6:  K_DATA = 32'h923f82a4;
      6'd7:  K_DATA = 32'hab1c5ed5;
      6'd8:  K_DATA = 32'hd807aa98;
      6'd9:  K_DATA = 32'h12835b01;
      6'd10: K_DATA = 32'h243185be;
      6'd11: K_DATA = 32'h550c7dc3;
      6'd12: K_DATA = 32'h72be5d74;
      6'd13: K_DATA = 32'h80deb1fe;
      6'd14: K_DATA = 32'h9bdc06a7;
      6'd15: K_DATA = 32'hc19bf174;
      6'd16: K_DATA = 32'he49b69c1;
      6'd17: K_DATA = 32'hefbe4786;
      6'd18: K_DATA = 32'h0fc19dc6;
      6'd19: K_DATA = 32'h240ca1cc;
      6'd20: K_DATA = 32'h2de92c6f;
      6'd21: K_DATA = 32'h4a7484aa;
      6'd22: K_DATA = 32'h5cb0a9dc;
      6'd23: K_DATA = 32'h76f988da;
      6'd24: K_DATA = 32'h983e5152;
      6'd25: K_DATA = 32'ha831c66d;
      6'd26: K_DATA = 32'hb00327c8;
      6'd27: K_DATA = 32'hbf597fc7;
      6'd28: K_DATA = 32'hc6e00bf3;
      6'd29: K_DATA = 32'hd5a79147;
      6'd30: K_DATA = 32'h06ca6351;
      6'd31: K_DATA = 32'h14292967;
      6'd32: K_DATA = 32'h27b70a85;
      6'd33: K_DATA = 32'h2e1b2138;
      6'd34: K_DATA = 32'h4d2c6dfc;
      6'd35: K_DATA = 32'h53380d13;
      6'd36: K_DATA = 32'h650a7354;
      6'd37: K_DATA = 32'h766a0abb;
      6'd38: K_DATA = 32'h81c2c92e;
      6'd39: K_DATA = 32'h92722c85;
      6'd40: K_DATA = 32'ha2bfe8a1;
      6'd41: K_DATA = 32'ha81a664b;
      6'd42: K_DATA = 32'hc24b8b70;
      6'd43: K_DATA = 32'hc76c51a3;
      6'd44: K_DATA = 32'hd192e819;
      6'd45: K_DATA = 32'hd6990624;
      6'd46: K_DATA = 32'hf40e3585;
      6'd47: K_DATA = 32'h106aa070;
      6'd48: K_DATA = 32'h19a4c116;
      6'd49: K_DATA = 32'h1e376c08;
      6'd50: K_DATA = 32'h2748774c;
      6'd51: K_DATA = 32'h34b0bcb5;
      6'd52: K_DATA = 32'h391c0cb3;
      6'd53: K_DATA = 32'h4ed8aa4a;
      6'd54: K_DATA = 32'h5b9cca4f;
      6'd55: K_DATA = 32'h682e6ff3;
      6'd56: K_DATA = 32'h748f82ee;
      6'd57: K_DATA = 32'h78a5636f;
      6'd58: K_DATA = 32'h84c87814;
      6'd59: K_DATA = 32'h8cc70208;
      6'd60: K_DATA = 32'h90befffa;
      6'd61: K_DATA = 32'ha4506ceb;
      6'd62: K_DATA = 32'hbef9a3f7;
      6'd63: K_DATA = 32'hc67178f2;
      default: K_DATA = '0;
    endcase
  end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Bench for sha256_msg_sched: array-based schedule model, "abc" vector table,
// backpressure, load gaps, CLR, mid-run reset and back-to-back blocks.
module tb_sha256_msg_sched;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b1;
  logic        CLR = 1'b0;
  logic        MSG_VALID = 1'b0;
  logic [31:0] MSG_DATA = '0;
  logic        W_READY = 1'b0;
  logic        MSG_READY;
  logic        W_VALID;
  logic [31:0] W_DATA;
  logic [31:0] K_DATA;
  logic [5:0]  W_IDX;
  logic        W_LAST;
  logic        BUSY;

  sha256_msg_sched dut (
    .ACLK      (ACLK),
    .ARESETN   (ARESETN),
    .CLR       (CLR),
    .MSG_VALID (MSG_VALID),
    .MSG_READY (MSG_READY),
    .MSG_DATA  (MSG_DATA),
    .W_VALID   (W_VALID),
    .W_READY   (W_READY),
    .W_DATA    (W_DATA),
    .K_DATA    (K_DATA),
    .W_IDX     (W_IDX),
    .W_LAST    (W_LAST),
    .BUSY      (BUSY)
  );

  always #5 ACLK = ~ACLK;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] k_tab [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic [31:0] mdl_w  [64];
  logic [31:0] cap_w  [64];
  logic [31:0] cap_k  [64];
  logic        cap_last [64];

  typedef struct {
    int          t;
    logic [31:0] w;
    logic [31:0] k;
    logic        last;
  } vec_t;
  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook recurrence over the whole 64-entry W array.
  function automatic void build_model(input logic [31:0] blk [16]);
    for (int t = 0; t < 64; t++) begin
      if (t < 16) begin
        mdl_w[t] = blk[t];
      end else begin
        mdl_w[t] = (rotr(mdl_w[t-2], 17) ^ rotr(mdl_w[t-2], 19) ^ (mdl_w[t-2] >> 10))
                 + mdl_w[t-7]
                 + (rotr(mdl_w[t-15], 7) ^ rotr(mdl_w[t-15], 18) ^ (mdl_w[t-15] >> 3))
                 + mdl_w[t-16];
      end
    end
  endfunction

  // Entered and left at a falling edge.
  task automatic load_block(input logic [31:0] blk [16], input int max_gap);
    for (int i = 0; i < 16; i++) begin
      int gaps;
      int budget;
      gaps = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      MSG_VALID = 1'b0;
      repeat (gaps) @(negedge ACLK);
      MSG_VALID = 1'b1;
      MSG_DATA  = blk[i];
      budget = 0;
      while (!MSG_READY && budget < 200) begin
        budget++;
        @(negedge ACLK);
      end
      chk("msg_ready_wait", {31'd0, MSG_READY}, 32'd1);
      chk("accept_not_run", {31'd0, W_VALID}, 32'd0);
      @(negedge ACLK);
    end
    MSG_VALID = 1'b0;
    chk("first_wvalid", {31'd0, W_VALID}, 32'd1);
    chk("first_idx", {26'd0, W_IDX}, 32'd0);
    chk("first_wdata", W_DATA, blk[0]);
    chk("first_kdata", K_DATA, k_tab[0]);
    chk("first_msg_ready", {31'd0, MSG_READY}, 32'd0);
    chk("first_busy", {31'd0, BUSY}, 32'd1);
  endtask

  task automatic collect(input bit rand_rdy);
    int t = 0;
    int cyc = 0;
    bit stall = 1'b0;
    bit rdy;
    logic [31:0] pw = '0;
    logic [31:0] pk = '0;
    logic [5:0]  pi = '0;
    while (t < 64 && cyc < 3000) begin
      cyc++;
      chk("run_wvalid", {31'd0, W_VALID}, 32'd1);
      if (stall) begin
        chk("stable_w", W_DATA, pw);
        chk("stable_k", K_DATA, pk);
        chk("stable_idx", {26'd0, W_IDX}, {26'd0, pi});
      end
      chk("w_idx", {26'd0, W_IDX}, 32'(t));
      chk("w_data", W_DATA, mdl_w[t]);
      chk("k_data", K_DATA, k_tab[t]);
      chk("w_last", {31'd0, W_LAST}, {31'd0, (t == 63)});
      chk("run_msg_ready", {31'd0, MSG_READY}, 32'd0);
      cap_w[t]    = W_DATA;
      cap_k[t]    = K_DATA;
      cap_last[t] = W_LAST;
      rdy = rand_rdy ? 1'($urandom_range(1, 0)) : 1'b1;
      W_READY = rdy;
      stall = !rdy;
      pw = W_DATA;
      pk = K_DATA;
      pi = W_IDX;
      if (rdy && W_VALID) t++;
      @(negedge ACLK);
    end
    W_READY = 1'b0;
    chk("collect_done", 32'(t), 32'd64);
    chk("post_wvalid", {31'd0, W_VALID}, 32'd0);
    chk("post_msg_ready", {31'd0, MSG_READY}, 32'd1);
    chk("post_busy", {31'd0, BUSY}, 32'd0);
    chk("post_idx", {26'd0, W_IDX}, 32'd0);
    chk("post_last", {31'd0, W_LAST}, 32'd0);
  endtask

  task automatic run_until(input logic [5:0] idx);
    int cyc = 0;
    while (W_IDX != idx && cyc < 200) begin
      cyc++;
      W_READY = 1'b1;
      @(negedge ACLK);
    end
    chk("run_until_idx", {26'd0, W_IDX}, {26'd0, idx});
    chk("run_until_w", W_DATA, mdl_w[idx]);
  endtask

  task automatic check_abc_table(input string tag);
    for (int i = 0; i < 5; i++) begin
      $display("[TB] %s vec t=%0d W=%08h K=%08h LAST=%0b", tag, vecs[i].t,
               cap_w[vecs[i].t], cap_k[vecs[i].t], cap_last[vecs[i].t]);
      chk("abc_w", cap_w[vecs[i].t], vecs[i].w);
      chk("abc_k", cap_k[vecs[i].t], vecs[i].k);
      chk("abc_last", {31'd0, cap_last[vecs[i].t]}, {31'd0, vecs[i].last});
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_msg_ready"}, {31'd0, MSG_READY}, 32'd1);
    chk({tag, "_wvalid"}, {31'd0, W_VALID}, 32'd0);
    chk({tag, "_wlast"}, {31'd0, W_LAST}, 32'd0);
    chk({tag, "_busy"}, {31'd0, BUSY}, 32'd0);
    chk({tag, "_idx"}, {26'd0, W_IDX}, 32'd0);
  endtask

  logic [31:0] abc  [16];
  logic [31:0] blk1 [16];
  logic [31:0] blk2 [16];

  initial begin
    for (int i = 0; i < 16; i++) abc[i] = '0;
    abc[0]  = 32'h61626380;
    abc[15] = 32'h00000018;
    build_model(abc);
    vecs[0] = '{0,  32'h61626380, 32'h428a2f98, 1'b0};
    vecs[1] = '{15, 32'h00000018, 32'hc19bf174, 1'b0};
    vecs[2] = '{16, 32'h61626380, 32'he49b69c1, 1'b0};
    vecs[3] = '{17, 32'h000f0000, 32'hefbe4786, 1'b0};
    vecs[4] = '{63, mdl_w[63],    32'hc67178f2, 1'b1};

    // Reset values before any clock edge.
    #1 ARESETN = 1'b0;
    #2;
    check_idle("reset");
    chk("reset_wdata", W_DATA, 32'd0);
    @(negedge ACLK);
    @(negedge ACLK);
    ARESETN = 1'b1;

    // "abc": plain, backpressure, load gaps.
    load_block(abc, 0);
    collect(1'b0);
    check_abc_table("abc");
    load_block(abc, 0);
    collect(1'b1);
    check_abc_table("abc_bp");
    load_block(abc, 3);
    collect(1'b0);
    check_abc_table("abc_gap");
    $display("[TB] abc scenarios done");

    // Random blocks with gaps and backpressure.
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 16; i++) blk1[i] = $urandom;
      build_model(blk1);
      load_block(blk1, 2);
      collect(1'b1);
      $display("[TB] random block %0d W63=%08h", b, mdl_w[63]);
    end

    // CLR at t=20 with simultaneous handshake.
    for (int i = 0; i < 16; i++) blk1[i] = $urandom;
    build_model(blk1);
    load_block(blk1, 0);
    run_until(6'd20);
    CLR = 1'b1;
    @(negedge ACLK);
    CLR = 1'b0;
    W_READY = 1'b0;
    check_idle("clr_run");
    // CLR on a partially loaded block.
    for (int i = 0; i < 5; i++) begin
      MSG_VALID = 1'b1;
      MSG_DATA  = 32'hdead0000 + 32'(i);
      @(negedge ACLK);
    end
    MSG_VALID = 1'b0;
    CLR = 1'b1;
    @(negedge ACLK);
    CLR = 1'b0;
    check_idle("clr_load");
    for (int i = 0; i < 16; i++) blk1[i] = $urandom;
    build_model(blk1);
    load_block(blk1, 0);
    collect(1'b0);
    $display("[TB] clr scenario done");

    // Reset at t=40, checked before the next rising edge.
    for (int i = 0; i < 16; i++) blk1[i] = $urandom;
    build_model(blk1);
    load_block(blk1, 0);
    run_until(6'd40);
    W_READY = 1'b0;
    #2 ARESETN = 1'b0;
    #1;
    check_idle("rst_run");
    chk("rst_run_wdata", W_DATA, 32'd0);
    @(negedge ACLK);
    @(negedge ACLK);
    ARESETN = 1'b1;
    for (int i = 0; i < 16; i++) blk1[i] = $urandom;
    build_model(blk1);
    load_block(blk1, 0);
    collect(1'b1);
    $display("[TB] reset scenario done");

    // Back-to-back: second block offered while the first streams.
    for (int i = 0; i < 16; i++) begin
      blk1[i] = $urandom;
      blk2[i] = $urandom;
    end
    build_model(blk1);
    load_block(blk1, 0);
    fork
      collect(1'b1);
      load_block(blk2, 0);
    join
    build_model(blk2);
    collect(1'b0);
    $display("[TB] back-to-back done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sha256_msg_sched.md
SHA256_MSG_SCHED -- requirements
Module: sha256_msg_sched

Interface
REQ-001 The block SHALL have one clock and one reset: ACLK, single clock; ARESETN, asynchronous, active-low.
REQ-002 Port ACLK SHALL be: input, 1 bit, system clock; all state changes on its rising edge.
REQ-003 Port ARESETN SHALL be: input, 1 bit, asynchronous active-low reset.
REQ-004 Port CLR SHALL be: input, 1 bit, synchronous abort; discards the block in progress.
REQ-005 Port MSG_VALID SHALL be: input, 1 bit, MSG_DATA carries a valid message word.
REQ-006 Port MSG_READY SHALL be: output, 1 bit, block accepts message words.
REQ-007 Port MSG_DATA SHALL be: input, 32 bits, one message word, big-endian; word 0 of the 512-bit block arrives first.
REQ-008 Port W_VALID SHALL be: output, 1 bit, W_DATA, K_DATA and W_IDX are valid.
REQ-009 Port W_READY SHALL be: input, 1 bit, the downstream compression round accepts the current word.
REQ-010 Port W_DATA SHALL be: output, 32 bits, schedule word W_t.
REQ-011 Port K_DATA SHALL be: output, 32 bits, round constant K_t.
REQ-012 Port W_IDX SHALL be: output, 6 bits, round index t.
REQ-013 Port W_LAST SHALL be: output, 1 bit, high when t = 63 while W_VALID is high.
REQ-014 Port BUSY SHALL be: output, 1 bit, high in RUN.

Function
REQ-015 The block SHALL implement two states: LOAD and RUN.
REQ-016 LOAD SHALL behave as follows.
- MSG_READY = 1 and W_VALID = 0.
- A word is accepted on each cycle with MSG_VALID & MSG_READY.
- The word shifts into a 16x32 window: the new word enters at slot 15, slot 0 is the oldest.
- A 4-bit load counter increments on each accepted word.
REQ-017 On acceptance of the 16th word, the block SHALL go to RUN on the next edge.
- W_VALID = 1 in the first RUN cycle, one cycle after the 16th handshake.
- W_IDX = 0 and W_DATA = word 0.
- MSG_READY = 0.
REQ-018 RUN SHALL behave as follows.
- W_DATA = window slot 0, a register.
- K_DATA = FIPS 180-4 K[W_IDX], from a combinational ROM driven by the registered W_IDX.
- W_VALID stays high and all outputs stay stable while W_READY = 0.
REQ-019 On each RUN cycle with W_VALID & W_READY, the block SHALL do the following in the same edge.
- Shift the window down one slot.
- Write slot 15 with σ1(w14) + w9 + σ0(w1) + w0, modulo 2^32, using pre-shift slot values.
- Increment W_IDX.
REQ-020 The σ functions SHALL be:
- σ0(x) = ROTR7 ^ ROTR18 ^ SHR3.
- σ1(x) = ROTR17 ^ ROTR19 ^ SHR10.
REQ-021 On the handshake at W_IDX = 63, the block SHALL do the following.
- Return to LOAD on the next edge, with W_VALID = 0, MSG_READY = 1, load counter = 0 and W_IDX wrapped to 0.
- Produce no gap cycle beyond that single state change.
REQ-022 MSG_VALID in RUN SHALL be ignored and SHALL NOT change the window.
REQ-023 CLR = 1 SHALL take priority over any simultaneous handshake.
- The next state is LOAD, with load counter = 0, W_IDX = 0 and W_VALID = 0.
- The window contents are don't-care.
REQ-024 CLR in LOAD with a partial block SHALL discard the already-loaded words.
REQ-025 BUSY SHALL equal (state == RUN), and W_LAST SHALL equal W_VALID & (W_IDX == 63).

Reset
REQ-026 While ARESETN = 0 the block SHALL be in LOAD with the following values, all independent of ACLK.
- load counter = 0, W_IDX = 0, window = 0.
- MSG_READY = 1, W_VALID = 0, W_LAST = 0, BUSY = 0.
REQ-027 Reset asserted mid-RUN SHALL abandon the block immediately, and after release the block SHALL accept a fresh 16 words.
REQ-028 Deassertion of ARESETN SHALL be released on a ACLK edge by the integrating level.

Verification
REQ-029 Scenario "abc" block: load 61626380, 14×00000000, 00000018 with W_READY = 1 -> the bench checks the following.
- W_VALID rises one cycle after the 16th word.
- W0 = 61626380 with K0 = 428a2f98.
- W15 = 00000018, W16 = 61626380, W17 = 000f0000.
- K63 = c67178f2 with W_LAST = 1.
- 64 consecutive valid cycles, then MSG_READY = 1.
REQ-030 Scenario backpressure: toggle W_READY pseudo-randomly over the "abc" block -> the W sequence is identical to REQ-029 and the outputs are stable during W_READY = 0 cycles.
REQ-031 Scenario load gaps: the same 16 words with MSG_VALID idle cycles between them -> results identical to REQ-029.
REQ-032 Scenario CLR: CLR at W_IDX = 20 with W_READY = 1 -> the bench checks the following.
- Next cycle W_VALID = 0, MSG_READY = 1, BUSY = 0.
- A following full block produces a correct schedule from W0.
REQ-033 Scenario reset mid-run: ARESETN low at W_IDX = 40 -> the bench checks the following.
- The outputs reach their reset values without a clock edge.
- After release, a new block loads and W0 equals its first word.
REQ-034 Scenario back-to-back: two blocks, with the second block's words presented while the first block is running -> the bench checks the following.
- No second-block word is accepted before the cycle after the first block's W_LAST handshake.
- The second schedule is correct.
